// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - PC next-source encodings, exception causes and FSM states
package pc_seq_pkg;

  typedef enum logic [2:0] {
    PCS_SEQ    = 3'd0,
    PCS_BRANCH = 3'd1,
    PCS_JUMP   = 3'd2,
    PCS_REG    = 3'd3,
    PCS_ILLOP  = 3'd4,
    PCS_XADR   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    EXC_NONE  = 2'b00,
    EXC_IRQ   = 2'b01,
    EXC_ILLOP = 2'b10
  } exc_cause_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode/control flags in, PC select and pipeline control out
interface pc_sequencer_if;

  logic       irq;
  logic       illop;
  logic       branch_taken;
  logic       jump;
  logic       jump_reg;
  logic       pc_kernel;
  logic [2:0] pc_src;
  logic       flush;
  logic       epc_we;
  logic       irq_ack;
  logic [1:0] exc_cause;

  modport master (
    output irq, illop, branch_taken, jump, jump_reg, pc_kernel,
    input  pc_src, flush, epc_we, irq_ack, exc_cause
  );

  modport slave (
    input  irq, illop, branch_taken, jump, jump_reg, pc_kernel,
    output pc_src, flush, epc_we, irq_ack, exc_cause
  );

endinterface

// File: rtl/pc_sequencer_irq_sync.sv
// rtl/pc_sequencer_irq_sync.sv - 2-flop irq synchronizer with armed rising-edge pulse
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic irq_edge
);

  logic       sync1;
  logic       sync2;
  logic       hist;
  logic       armed;
  logic [1:0] fill;

  // fill[1] marks sync2 as holding a real sample rather than its reset value;
  // an edge only counts once a genuine synchronized low has been seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      hist  <= sync2;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && !sync2)
        armed <= 1'b1;
    end
  end

  assign irq_edge = armed & sync2 & ~hist;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC source selection, exception entry and IF/ID flush control
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  seq_state_t state;
  seq_state_t state_nxt;
  exc_cause_t exc_q;
  logic       irq_edge;
  logic       irq_pending;
  logic       take_illop;
  logic       take_irq;
  logic [2:0] pc_src_c;
  logic       flush_c;
  logic       epc_we_c;
  logic       irq_ack_c;

  irq_sync u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .irq      (bus.irq),
    .irq_edge (irq_edge)
  );

  // Events are only honoured in RUN; in FLUSH they belong to a killed instruction.
  always_comb begin
    take_illop = (state == ST_RUN) && bus.illop;
    take_irq   = (state == ST_RUN) && !bus.illop && irq_pending && !bus.pc_kernel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_RUN;
    if (state == ST_RUN && (take_illop || take_irq))
      state_nxt = ST_FLUSH;
  end

  always_comb begin
    pc_src_c  = PCS_SEQ;
    flush_c   = 1'b0;
    epc_we_c  = 1'b0;
    irq_ack_c = 1'b0;
    if (reset) begin
      case (state)
        ST_RUN: begin
          if (take_illop) begin
            pc_src_c = PCS_ILLOP;
            epc_we_c = 1'b1;
            flush_c  = 1'b1;
          end else if (take_irq) begin
            pc_src_c  = PCS_XADR;
            epc_we_c  = 1'b1;
            flush_c   = 1'b1;
            irq_ack_c = 1'b1;
          end else if (bus.branch_taken) begin
            pc_src_c = PCS_BRANCH;
            flush_c  = 1'b1;
          end else if (bus.jump) begin
            pc_src_c = PCS_JUMP;
            flush_c  = 1'b1;
          end else if (bus.jump_reg) begin
            pc_src_c = PCS_REG;
            flush_c  = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_c = 1'b1;
        end
        default: begin
          pc_src_c = PCS_SEQ;
        end
      endcase
    end
  end

  // Clearing on acknowledge wins over a coincident edge, so that edge is absorbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      irq_pending <= 1'b0;
    else if (irq_ack_c)
      irq_pending <= 1'b0;
    else if (irq_edge)
      irq_pending <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      exc_q <= EXC_NONE;
    else if (take_illop)
      exc_q <= EXC_ILLOP;
    else if (take_irq)
      exc_q <= EXC_IRQ;
  end

  assign bus.pc_src    = pc_src_c;
  assign bus.flush     = flush_c;
  assign bus.epc_we    = epc_we_c;
  assign bus.irq_ack   = irq_ack_c;
  assign bus.exc_cause = exc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  typedef struct packed {
    logic [2:0] ps;
    logic       fl;
    logic       ew;
    logic       ak;
    logic [1:0] ec;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   checks;
  int   errors;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive inputs just after the edge, queue the outputs expected in that cycle.
  task automatic cyc(input logic rs, input logic il, input logic br, input logic jp,
                     input logic jr, input logic kn, input logic iq,
                     input logic [2:0] ps, input logic fl, input logic ew,
                     input logic ak, input logic [1:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rs;
    bus.illop        = il;
    bus.branch_taken = br;
    bus.jump         = jp;
    bus.jump_reg     = jr;
    bus.pc_kernel    = kn;
    bus.irq          = iq;
    e.ps = ps; e.fl = fl; e.ew = ew; e.ak = ak; e.ec = ec;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic kn, input logic iq, input logic [1:0] ec);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, kn, iq, 3'd0, 1'b0, 1'b0, 1'b0, ec);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a.ps = bus.pc_src; a.fl = bus.flush; a.ew = bus.epc_we;
      a.ak = bus.irq_ack; a.ec = bus.exc_cause;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got pc_src=%0d flush=%b epc_we=%b irq_ack=%b exc_cause=%b, want pc_src=%0d flush=%b epc_we=%b irq_ack=%b exc_cause=%b",
                 $time, a.ps, a.fl, a.ew, a.ak, a.ec, e.ps, e.fl, e.ew, e.ak, e.ec);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.irq = 1'b0; bus.illop = 1'b0; bus.branch_taken = 1'b0;
    bus.jump = 1'b0; bus.jump_reg = 1'b0; bus.pc_kernel = 1'b0;

    // reset state, outputs gated even with events present
    cyc(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00);
    cyc(0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00);
    idle(4, 0, 0, 2'b00);

    // irq edge in user mode: ack three cycles after the rise, then flush
    idle(3, 0, 1, 2'b00);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd5, 1, 1, 1, 2'b00);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 2'b01);
    idle(1, 0, 1, 2'b01);

    // illop + branch with irq pending: illop wins, irq follows after the flush
    idle(3, 0, 0, 2'b01);
    idle(3, 0, 1, 2'b01);
    cyc(1, 1, 1, 0, 0, 0, 1, 3'd4, 1, 1, 0, 2'b01);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 2'b10);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd5, 1, 1, 1, 2'b10);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 2'b01);
    idle(1, 0, 1, 2'b01);

    // irq edge in kernel mode stays pending until user mode
    idle(3, 0, 0, 2'b01);
    idle(10, 1, 1, 2'b01);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd5, 1, 1, 1, 2'b01);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 2'b01);
    idle(1, 0, 1, 2'b01);

    // kernel-mode illop; FLUSH ignores jump and illop, then back in RUN
    cyc(1, 1, 0, 0, 0, 1, 1, 3'd4, 1, 1, 0, 2'b01);
    cyc(1, 1, 0, 1, 0, 1, 1, 3'd0, 1, 0, 0, 2'b10);
    idle(1, 1, 1, 2'b10);
    cyc(1, 0, 0, 1, 0, 1, 1, 3'd2, 1, 0, 0, 2'b10);

    // branch/jump priority
    cyc(1, 0, 0, 1, 1, 0, 1, 3'd2, 1, 0, 0, 2'b10);
    cyc(1, 0, 1, 0, 0, 0, 1, 3'd1, 1, 0, 0, 2'b10);
    idle(1, 0, 1, 2'b10);
    cyc(1, 0, 0, 0, 1, 0, 1, 3'd3, 1, 0, 0, 2'b10);
    cyc(1, 0, 1, 1, 1, 0, 1, 3'd1, 1, 0, 0, 2'b10);

    // reset mid-FLUSH with irq high; no ack until irq goes low then high
    cyc(1, 1, 0, 0, 0, 0, 1, 3'd4, 1, 1, 0, 2'b10);
    cyc(0, 0, 0, 1, 0, 0, 1, 3'd0, 0, 0, 0, 2'b00);
    cyc(0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, 2'b00);
    idle(6, 0, 1, 2'b00);
    idle(3, 0, 0, 2'b00);
    idle(3, 0, 1, 2'b00);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd5, 1, 1, 1, 2'b00);
    cyc(1, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, 2'b01);
    idle(2, 0, 0, 2'b01);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
